// File: rtl/inst_pkg.sv
// Shared encoder package: RV64 opcode constants, encoder FSM state
// encoding and the signed 12-bit immediate range bounds.
package inst_pkg;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic signed [63:0] IMM_MIN = -64'sd2048;
    localparam logic signed [63:0] IMM_MAX = 64'sd2047;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/inst_encoder_if.sv
// Field-set handshake plus instruction-memory write side of the encoder.
// master: producer of field sets / observer; slave: the encoder.
interface inst_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              valid_i;
    logic              ready_o;
    logic [6:0]        opcode_i;
    logic [2:0]        funct3_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [63:0]       imm_i;
    logic              we_o;
    logic [ADDR_W-1:0] addr_o;
    logic [31:0]       data_o;
    logic              err_o;
    logic              full_o;
    logic [ADDR_W:0]   count_o;

    modport master (
        output valid_i, opcode_i, funct3_i, rd_i, rs1_i, rs2_i, imm_i,
        input  ready_o, we_o, addr_o, data_o, err_o, full_o, count_o
    );

    modport slave (
        input  valid_i, opcode_i, funct3_i, rd_i, rs1_i, rs2_i, imm_i,
        output ready_o, we_o, addr_o, data_o, err_o, full_o, count_o
    );
endinterface

// File: rtl/inst_pack.sv
// Combinational packer: scatters fields into I/load/S-type words.
// Ports: opcode/funct3/rd/rs1/rs2/imm in; o_word, o_legal out.
module inst_pack
    import inst_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [63:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_legal
);

    logic w_op_ok;
    logic w_in_range;

    // Equivalent to imm[63:11] all matching imm[11].
    assign w_in_range = ($signed(i_imm) >= IMM_MIN) &&
                        ($signed(i_imm) <= IMM_MAX);

    always_comb begin
        o_word  = 32'h0;
        w_op_ok = 1'b0;
        case (i_opcode)
            OP_IMM, OP_LOAD: begin
                o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                w_op_ok = 1'b1;
            end
            OP_STORE: begin
                o_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:0], i_opcode};
                w_op_ok = 1'b1;
            end
            default: begin
                o_word  = 32'h0;
                w_op_ok = 1'b0;
            end
        endcase
    end

    assign o_legal = w_op_ok & w_in_range;

endmodule

// File: rtl/inst_encoder.sv
// Sequential instruction encoder/loader filling instruction memory.
// Ports: clk_i, rst_i (sync high), clear_i (soft clear), bus (slave).
module inst_encoder
    import inst_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clear_i,
    inst_encoder_if.slave  bus
);

    localparam int CW = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              r_err;
    logic              r_full;
    logic [CW-1:0]     r_count;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_accept;
    logic              w_last;
    logic              w_init;

    inst_pack u_pack (
        .i_opcode (bus.opcode_i),
        .i_funct3 (bus.funct3_i),
        .i_rd     (bus.rd_i),
        .i_rs1    (bus.rs1_i),
        .i_rs2    (bus.rs2_i),
        .i_imm    (bus.imm_i),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    assign w_init   = rst_i | clear_i;
    assign w_accept = (r_state == ST_IDLE) & bus.valid_i;
    assign w_last   = (r_addr == {ADDR_W{1'b1}});

    always_ff @(posedge clk_i) begin
        if (w_init) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_legal) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: w_next = w_last ? ST_FULL : ST_IDLE;
            ST_FULL:  w_next = ST_FULL;
            default:  w_next = ST_IDLE;
        endcase
    end

    // we_o is high exactly while the FSM sits in WRITE.
    always_ff @(posedge clk_i) begin
        if (w_init) begin
            r_we    <= 1'b0;
            r_addr  <= BASE;
            r_data  <= 32'h0;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
            r_count <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_accept && w_legal) begin
                r_we   <= 1'b1;
                r_data <= w_word;
            end
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
            end
            if (r_state == ST_WRITE) begin
                r_count <= r_count + CW'(1);
                if (w_last) begin
                    r_full <= 1'b1;
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

    assign bus.ready_o = (r_state == ST_IDLE);
    assign bus.we_o    = r_we;
    assign bus.addr_o  = r_addr;
    assign bus.data_o  = r_data;
    assign bus.err_o   = r_err;
    assign bus.full_o  = r_full;
    assign bus.count_o = r_count;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed testbench for inst_encoder: one ADDR_W=6 instance for
// encoding/error/reset scenarios, one ADDR_W=2 instance for FULL.
module tb_inst_encoder;
    import inst_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    inst_encoder_if #(.ADDR_W(6)) bus6 ();
    inst_encoder_if #(.ADDR_W(2)) bus2 ();

    inst_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dut6 (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clr),
        .bus     (bus6)
    );

    inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clr),
        .bus     (bus2)
    );

    task automatic set6(input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [63:0] imm);
        bus6.opcode_i = op;
        bus6.funct3_i = f3;
        bus6.rd_i     = rd;
        bus6.rs1_i    = rs1;
        bus6.rs2_i    = rs2;
        bus6.imm_i    = imm;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr = 1'b0;
        bus6.valid_i = 1'b0;
        bus2.valid_i = 1'b0;
        set6(7'h0, 3'h0, 5'h0, 5'h0, 5'h0, 64'h0);
        bus2.opcode_i = 7'h0; bus2.funct3_i = 3'h0; bus2.rd_i = 5'h0;
        bus2.rs1_i = 5'h0; bus2.rs2_i = 5'h0; bus2.imm_i = 64'h0;
        repeat (2) @(negedge clk);
        checks++; if (bus6.ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0h exp=1", bus6.ready_o); end
        checks++; if (bus6.we_o !== 1'b0) begin errors++; $display("FAIL rst_we got=%0h exp=0", bus6.we_o); end
        checks++; if (bus6.addr_o !== 6'd0) begin errors++; $display("FAIL rst_addr got=%0h exp=0", bus6.addr_o); end
        checks++; if (bus6.data_o !== 32'h0) begin errors++; $display("FAIL rst_data got=%0h exp=0", bus6.data_o); end
        checks++; if (bus6.err_o !== 1'b0) begin errors++; $display("FAIL rst_err got=%0h exp=0", bus6.err_o); end
        checks++; if (bus6.full_o !== 1'b0) begin errors++; $display("FAIL rst_full got=%0h exp=0", bus6.full_o); end
        checks++; if (bus6.count_o !== 7'd0) begin errors++; $display("FAIL rst_count got=%0h exp=0", bus6.count_o); end
        checks++; if (bus2.ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready2 got=%0h exp=1", bus2.ready_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addi();
        set6(OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 64'd5);
        bus6.valid_i = 1'b1;
        @(negedge clk);
        checks++; if (bus6.we_o !== 1'b1) begin errors++; $display("FAIL addi_we got=%0h exp=1", bus6.we_o); end
        checks++; if (bus6.addr_o !== 6'd0) begin errors++; $display("FAIL addi_addr got=%0h exp=0", bus6.addr_o); end
        checks++; if (bus6.data_o !== 32'h00500093) begin errors++; $display("FAIL addi_data got=%0h exp=00500093", bus6.data_o); end
        checks++; if (bus6.ready_o !== 1'b0) begin errors++; $display("FAIL addi_ready got=%0h exp=0", bus6.ready_o); end
        bus6.valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus6.we_o !== 1'b0) begin errors++; $display("FAIL addi_we_end got=%0h exp=0", bus6.we_o); end
        checks++; if (bus6.count_o !== 7'd1) begin errors++; $display("FAIL addi_count got=%0h exp=1", bus6.count_o); end
        checks++; if (bus6.addr_o !== 6'd1) begin errors++; $display("FAIL addi_addr_next got=%0h exp=1", bus6.addr_o); end
    endtask

    task automatic test_store();
        set6(OP_STORE, 3'd3, 5'd0, 5'd3, 5'd2, 64'hFFFF_FFFF_FFFF_FFF8);
        bus6.valid_i = 1'b1;
        @(negedge clk);
        bus6.valid_i = 1'b0;
        checks++; if (bus6.we_o !== 1'b1) begin errors++; $display("FAIL sd_we got=%0h exp=1", bus6.we_o); end
        checks++; if (bus6.addr_o !== 6'd1) begin errors++; $display("FAIL sd_addr got=%0h exp=1", bus6.addr_o); end
        checks++; if (bus6.data_o !== 32'hFE21BC23) begin errors++; $display("FAIL sd_data got=%0h exp=fe21bc23", bus6.data_o); end
        @(negedge clk);
        checks++; if (bus6.count_o !== 7'd2) begin errors++; $display("FAIL sd_count got=%0h exp=2", bus6.count_o); end
    endtask

    task automatic test_load();
        set6(OP_LOAD, 3'd3, 5'd5, 5'd6, 5'd0, 64'd16);
        bus6.valid_i = 1'b1;
        @(negedge clk);
        bus6.valid_i = 1'b0;
        checks++; if (bus6.addr_o !== 6'd2) begin errors++; $display("FAIL ld_addr got=%0h exp=2", bus6.addr_o); end
        checks++; if (bus6.data_o !== 32'h01033283) begin errors++; $display("FAIL ld_data got=%0h exp=01033283", bus6.data_o); end
        @(negedge clk);
        checks++; if (bus6.count_o !== 7'd3) begin errors++; $display("FAIL ld_count got=%0h exp=3", bus6.count_o); end
    endtask

    task automatic test_bounds();
        set6(OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 64'd2047);
        bus6.valid_i = 1'b1;
        @(negedge clk);
        bus6.valid_i = 1'b0;
        checks++; if (bus6.we_o !== 1'b1) begin errors++; $display("FAIL max_we got=%0h exp=1", bus6.we_o); end
        checks++; if (bus6.data_o !== 32'h7FF00093) begin errors++; $display("FAIL max_data got=%0h exp=7ff00093", bus6.data_o); end
        @(negedge clk);
        set6(OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_F800);
        bus6.valid_i = 1'b1;
        @(negedge clk);
        bus6.valid_i = 1'b0;
        checks++; if (bus6.addr_o !== 6'd4) begin errors++; $display("FAIL min_addr got=%0h exp=4", bus6.addr_o); end
        checks++; if (bus6.data_o !== 32'h80000093) begin errors++; $display("FAIL min_data got=%0h exp=80000093", bus6.data_o); end
        @(negedge clk);
        checks++; if (bus6.count_o !== 7'd5) begin errors++; $display("FAIL bnd_count got=%0h exp=5", bus6.count_o); end
        checks++; if (bus6.err_o !== 1'b0) begin errors++; $display("FAIL bnd_err got=%0h exp=0", bus6.err_o); end
    endtask

    task automatic test_range_err();
        logic [6:0]  ops  [3];
        logic [63:0] imms [3];
        logic [5:0]  ea;
        ops[0] = OP_IMM;       imms[0] = 64'd2048;
        ops[1] = OP_IMM;       imms[1] = 64'hFFFF_FFFF_FFFF_F7FF;
        ops[2] = 7'b0110011;   imms[2] = 64'd5;
        for (int i = 0; i < 3; i++) begin
            ea = 6'd5;
            if (i > 0) begin
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                ea = 6'd0;
                checks++; if (bus6.err_o !== 1'b0) begin errors++; $display("FAIL err_clr%0d got=%0h exp=0", i, bus6.err_o); end
            end
            set6(ops[i], 3'd0, 5'd1, 5'd0, 5'd0, imms[i]);
            bus6.valid_i = 1'b1;
            @(negedge clk);
            bus6.valid_i = 1'b0;
            checks++; if (bus6.err_o !== 1'b1) begin errors++; $display("FAIL err_set%0d got=%0h exp=1", i, bus6.err_o); end
            checks++; if (bus6.we_o !== 1'b0) begin errors++; $display("FAIL err_we%0d got=%0h exp=0", i, bus6.we_o); end
            checks++; if (bus6.ready_o !== 1'b1) begin errors++; $display("FAIL err_ready%0d got=%0h exp=1", i, bus6.ready_o); end
            @(negedge clk);
            checks++; if (bus6.addr_o !== ea) begin errors++; $display("FAIL err_addr%0d got=%0h exp=%0h", i, bus6.addr_o, ea); end
            checks++; if (bus6.count_o !== 7'(ea)) begin errors++; $display("FAIL err_count%0d got=%0h exp=%0h", i, bus6.count_o, ea); end
        end
        set6(OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 64'd5);
        bus6.valid_i = 1'b1;
        @(negedge clk);
        bus6.valid_i = 1'b0;
        checks++; if (bus6.we_o !== 1'b1) begin errors++; $display("FAIL err_next_we got=%0h exp=1", bus6.we_o); end
        checks++; if (bus6.addr_o !== 6'd0) begin errors++; $display("FAIL err_next_addr got=%0h exp=0", bus6.addr_o); end
        @(negedge clk);
        checks++; if (bus6.err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0h exp=1", bus6.err_o); end
        checks++; if (bus6.count_o !== 7'd1) begin errors++; $display("FAIL err_next_count got=%0h exp=1", bus6.count_o); end
    endtask

    task automatic test_clear_priority();
        set6(OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 64'd5);
        bus6.valid_i = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        bus6.valid_i = 1'b0;
        checks++; if (bus6.we_o !== 1'b0) begin errors++; $display("FAIL clr_we got=%0h exp=0", bus6.we_o); end
        checks++; if (bus6.addr_o !== 6'd0) begin errors++; $display("FAIL clr_addr got=%0h exp=0", bus6.addr_o); end
        checks++; if (bus6.count_o !== 7'd0) begin errors++; $display("FAIL clr_count got=%0h exp=0", bus6.count_o); end
        checks++; if (bus6.err_o !== 1'b0) begin errors++; $display("FAIL clr_err got=%0h exp=0", bus6.err_o); end
        checks++; if (bus6.ready_o !== 1'b1) begin errors++; $display("FAIL clr_ready got=%0h exp=1", bus6.ready_o); end
        @(negedge clk);
        checks++; if (bus6.we_o !== 1'b0) begin errors++; $display("FAIL clr_we_late got=%0h exp=0", bus6.we_o); end
    endtask

    task automatic test_reset_mid();
        set6(OP_LOAD, 3'd3, 5'd5, 5'd6, 5'd0, 64'd16);
        bus6.valid_i = 1'b1;
        @(negedge clk);
        bus6.valid_i = 1'b0;
        checks++; if (bus6.we_o !== 1'b1) begin errors++; $display("FAIL rmid_we got=%0h exp=1", bus6.we_o); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus6.we_o !== 1'b0) begin errors++; $display("FAIL rmid_we_off got=%0h exp=0", bus6.we_o); end
        checks++; if (bus6.data_o !== 32'h0) begin errors++; $display("FAIL rmid_data got=%0h exp=0", bus6.data_o); end
        checks++; if (bus6.count_o !== 7'd0) begin errors++; $display("FAIL rmid_count got=%0h exp=0", bus6.count_o); end
        checks++; if (bus6.addr_o !== 6'd0) begin errors++; $display("FAIL rmid_addr got=%0h exp=0", bus6.addr_o); end
        checks++; if (bus6.ready_o !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%0h exp=1", bus6.ready_o); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus6.we_o !== 1'b0) begin errors++; $display("FAIL rmid_we_after got=%0h exp=0", bus6.we_o); end
        checks++; if (bus6.count_o !== 7'd0) begin errors++; $display("FAIL rmid_count_after got=%0h exp=0", bus6.count_o); end
    endtask

    task automatic test_full();
        int writes;
        writes = 0;
        bus2.opcode_i = OP_IMM; bus2.funct3_i = 3'd0; bus2.rd_i = 5'd1;
        bus2.rs1_i = 5'd0; bus2.rs2_i = 5'd0; bus2.imm_i = 64'd5;
        bus2.valid_i = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bus2.we_o === 1'b1) begin
                checks++; if (bus2.addr_o !== 2'(writes)) begin errors++; $display("FAIL full_addr%0d got=%0h exp=%0h", writes, bus2.addr_o, 2'(writes)); end
                writes++;
            end
        end
        checks++; if (writes != 4) begin errors++; $display("FAIL full_writes got=%0d exp=4", writes); end
        checks++; if (bus2.full_o !== 1'b1) begin errors++; $display("FAIL full_flag got=%0h exp=1", bus2.full_o); end
        checks++; if (bus2.ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got=%0h exp=0", bus2.ready_o); end
        checks++; if (bus2.count_o !== 3'd4) begin errors++; $display("FAIL full_count got=%0h exp=4", bus2.count_o); end
        bus2.valid_i = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (bus2.addr_o !== 2'd0) begin errors++; $display("FAIL fclr_addr got=%0h exp=0", bus2.addr_o); end
        checks++; if (bus2.full_o !== 1'b0) begin errors++; $display("FAIL fclr_full got=%0h exp=0", bus2.full_o); end
        checks++; if (bus2.err_o !== 1'b0) begin errors++; $display("FAIL fclr_err got=%0h exp=0", bus2.err_o); end
        checks++; if (bus2.ready_o !== 1'b1) begin errors++; $display("FAIL fclr_ready got=%0h exp=1", bus2.ready_o); end
        checks++; if (bus2.count_o !== 3'd0) begin errors++; $display("FAIL fclr_count got=%0h exp=0", bus2.count_o); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store();
        test_load();
        test_bounds();
        test_range_err();
        test_clear_priority();
        test_reset_mid();
        test_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
